// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet injector: header field layout
// helpers and the transmit FSM state type.
package noc_pkg;

  localparam int CLASS_WIDTH = 3;

  typedef enum logic [0:0] {
    IDLE,
    PAYLOAD
  } tx_state_t;

  // Header layout from the top bit down: dest, class, source ID, then zeros.
  function automatic int hdr_dest_msb(input int flit_width);
    return flit_width - 1;
  endfunction

  function automatic int hdr_class_msb(input int flit_width, input int dest_width);
    return flit_width - dest_width - 1;
  endfunction

  function automatic int hdr_src_msb(input int flit_width, input int dest_width);
    return flit_width - dest_width - CLASS_WIDTH - 1;
  endfunction

endpackage

// File: rtl/noc_packet_tx.sv
// Local-port packet injector: turns a request plus a payload stream into a
// header flit followed by payload flits on one per-VC valid/ready link.
module noc_packet_tx
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 1,
  parameter int DEST_WIDTH = 5,
  parameter int SRC_ID     = 0,
  parameter int MAX_LEN    = 16,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1),
  parameter int VC_WIDTH   = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEST_WIDTH-1:0]  req_dest,
  input  logic [CLASS_WIDTH-1:0] req_class,
  input  logic [VC_WIDTH-1:0]    req_vc,
  input  logic [LEN_WIDTH-1:0]   req_len,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [FLIT_WIDTH-1:0]  data_flit,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic                   out_last,
  output logic [VCHANNELS-1:0]   out_valid,
  input  logic [VCHANNELS-1:0]   out_ready,
  output logic                   busy,
  output logic                   pkt_sent
);

  localparam int DEST_MSB  = hdr_dest_msb(FLIT_WIDTH);
  localparam int CLASS_MSB = hdr_class_msb(FLIT_WIDTH, DEST_WIDTH);
  localparam int SRC_MSB   = hdr_src_msb(FLIT_WIDTH, DEST_WIDTH);

  tx_state_t             state, state_next;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [FLIT_WIDTH-1:0] flit_q;
  logic [FLIT_WIDTH-1:0] header;
  logic                  last_q;
  logic                  valid_q;
  logic [VC_WIDTH-1:0]   vc_q;
  logic [VCHANNELS-1:0]  vc_onehot;
  logic                  sel_ready;
  logic                  reg_free;
  logic                  req_fire;
  logic                  data_fire;

  // Only the ready of the packet's own VC matters; the others are ignored.
  assign vc_onehot   = VCHANNELS'(1) << vc_q;
  assign sel_ready   = |(out_ready & vc_onehot);
  assign reg_free    = !valid_q || sel_ready;
  assign len_clamped = (req_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : req_len;
  assign req_fire    = req_valid && req_ready;
  assign data_fire   = data_valid && data_ready;

  always_comb begin
    header = '0;
    header[DEST_MSB -: DEST_WIDTH]   = req_dest;
    header[CLASS_MSB -: CLASS_WIDTH] = req_class;
    header[SRC_MSB -: DEST_WIDTH]    = DEST_WIDTH'(SRC_ID);
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reg_free;
        if (req_valid && reg_free && (len_clamped != '0)) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        data_ready = reg_free;
        if (data_valid && reg_free && (cnt == LEN_WIDTH'(1))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Output register reloads in the same cycle it drains, so streaming has no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q  <= '0;
      last_q  <= 1'b0;
      vc_q    <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else if (req_fire) begin
      flit_q  <= header;
      last_q  <= (len_clamped == '0);
      vc_q    <= req_vc;
      valid_q <= 1'b1;
      cnt     <= len_clamped;
    end else if (data_fire) begin
      flit_q  <= data_flit;
      last_q  <= (cnt == LEN_WIDTH'(1));
      valid_q <= 1'b1;
      cnt     <= cnt - LEN_WIDTH'(1);
    end else if (valid_q && sel_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_flit  = flit_q;
  assign out_last  = last_q;
  assign out_valid = valid_q ? vc_onehot : '0;
  assign busy      = (state == PAYLOAD) || valid_q;
  assign pkt_sent  = valid_q && last_q && sel_ready;

endmodule

// File: tb/tb_noc_packet_tx.sv
// Self-checking bench for noc_packet_tx: directed table, hand-written corner
// sequences and a randomized phase, all scored against a flit-queue model.
module tb_noc_packet_tx;

  localparam int FW   = 32;
  localparam int VCS  = 2;
  localparam int DW   = 5;
  localparam int SRC  = 5;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int VW   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   req_dest;
  logic [2:0]      req_class;
  logic [VW-1:0]   req_vc;
  logic [LW-1:0]   req_len;
  logic            req_valid;
  logic            req_ready;
  logic [FW-1:0]   data_flit;
  logic            data_valid;
  logic            data_ready;
  logic [FW-1:0]   out_flit;
  logic            out_last;
  logic [VCS-1:0]  out_valid;
  logic [VCS-1:0]  out_ready;
  logic            busy;
  logic            pkt_sent;

  logic [VCS-1:0]  fixed_ready;
  logic [VCS-1:0]  rand_ready;
  logic            rand_mode;

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rand_ready : fixed_ready;

  always @(posedge clk) rand_ready <= VCS'($urandom_range(0, 3));

  noc_packet_tx #(
    .FLIT_WIDTH(FW), .VCHANNELS(VCS), .DEST_WIDTH(DW), .SRC_ID(SRC),
    .MAX_LEN(MAXL), .LEN_WIDTH(LW), .VC_WIDTH(VW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_dest(req_dest), .req_class(req_class), .req_vc(req_vc), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready),
    .data_flit(data_flit), .data_valid(data_valid), .data_ready(data_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .pkt_sent(pkt_sent)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
    logic [VW-1:0] vc;
    logic          hdr;
  } exp_t;

  typedef struct {
    logic [DW-1:0] dest;
    logic [2:0]    cls;
    logic [VW-1:0] vc;
    logic [LW-1:0] len;
    logic [FW-1:0] base;
    logic [FW-1:0] exp_hdr;
    int            exp_flits;
  } vec_t;

  exp_t          expq[$];
  exp_t          e;
  int            xfer_cyc[$];
  int            rem = 0;
  int            cyc = 0;
  int            pkt_flits = 0;
  logic [VW-1:0] cur_vc = '0;
  logic [FW-1:0] last_hdr = '0;
  logic          mon_en = 1'b0;
  logic          stalled_prev = 1'b0;
  logic [FW-1:0] prev_flit = '0;
  logic [VCS-1:0] prev_valid = '0;
  logic          prev_last = 1'b0;

  function automatic logic [FW-1:0] mkHdr(input logic [DW-1:0] d, input logic [2:0] c);
    return (FW'(d) << (FW - DW)) | (FW'(c) << (FW - DW - 3)) | (FW'(SRC) << (FW - 2 * DW - 3));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=handshake", name);
  endtask

  // Scoreboard: every accepted request/data word becomes an expected flit,
  // every output transfer pops one; a stalled flit must not change.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (stalled_prev) begin
        chk("hold_flit", 64'(out_flit), 64'(prev_flit));
        chk("hold_valid", 64'(out_valid), 64'(prev_valid));
        chk("hold_last", 64'(out_last), 64'(prev_last));
      end
      if ((out_valid & out_ready) != '0) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_flit actual=%0h required=none", out_flit);
        end else begin
          e = expq.pop_front();
          chk("flit", 64'(out_flit), 64'(e.flit));
          chk("last", 64'(out_last), 64'(e.last));
          chk("vc_onehot", 64'(out_valid), 64'(VCS'(1) << e.vc));
          chk("pkt_sent", 64'(pkt_sent), 64'(e.last));
          if (e.hdr) begin
            last_hdr  = out_flit;
            pkt_flits = 0;
          end
          pkt_flits++;
          xfer_cyc.push_back(cyc);
        end
        stalled_prev = 1'b0;
      end else begin
        chk("pkt_sent_quiet", 64'(pkt_sent), 64'(0));
        stalled_prev = (out_valid != '0);
      end
      prev_flit  = out_flit;
      prev_valid = out_valid;
      prev_last  = out_last;
      if (rst) begin
        expq.delete();
        rem = 0;
        stalled_prev = 1'b0;
      end else begin
        if (rem == 0) chk("data_ready_between_pkts", 64'(data_ready), 64'(0));
        else          chk("req_ready_in_payload", 64'(req_ready), 64'(0));
        if (req_valid && req_ready) begin
          e.flit = mkHdr(req_dest, req_class);
          e.last = (req_len == '0);
          e.vc   = req_vc;
          e.hdr  = 1'b1;
          expq.push_back(e);
          cur_vc = req_vc;
          rem    = (int'(req_len) > MAXL) ? MAXL : int'(req_len);
        end else if (data_valid && data_ready && rem > 0) begin
          e.flit = data_flit;
          e.last = (rem == 1);
          e.vc   = cur_vc;
          e.hdr  = 1'b0;
          expq.push_back(e);
          rem--;
        end
      end
    end
  end

  task automatic sendReq(input logic [DW-1:0] d, input logic [2:0] c,
                         input logic [VW-1:0] v, input logic [LW-1:0] l);
    int to = 0;
    req_dest  = d;
    req_class = c;
    req_vc    = v;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready) begin
      to++;
      if (to > 300) begin
        timeoutFail("req_accept");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic sendData(input logic [FW-1:0] w);
    int to = 0;
    data_flit = w;
    while (to <= 300) begin
      if (rand_mode && $urandom_range(0, 3) == 0) begin
        data_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        data_valid = 1'b1;
        @(negedge clk);
        if (data_ready) begin
          @(posedge clk);
          #1;
          data_valid = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
      to++;
    end
    data_valid = 1'b0;
    timeoutFail("data_accept");
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [2:0] c,
                               input logic [VW-1:0] v, input logic [LW-1:0] l,
                               input logic [FW-1:0] base);
    int n;
    n = (int'(l) > MAXL) ? MAXL : int'(l);
    sendReq(d, c, v, l);
    for (int i = 0; i < n; i++) sendData(base + FW'(i));
  endtask

  task automatic waitIdle();
    int to = 0;
    @(negedge clk);
    while (busy || expq.size() != 0) begin
      to++;
      if (to > 300) begin
        timeoutFail("drain");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    waitIdle();
    chk("pkt_header", 64'(last_hdr), 64'(v.exp_hdr));
    chk("pkt_flit_count", 64'(pkt_flits), 64'(v.exp_flits));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{dest: 5'd3,  cls: 3'd1, vc: 1'b0, len: 5'd0,  base: 32'h0,     exp_hdr: 32'h1928_0000, exp_flits: 1};
    vecs[1] = '{dest: 5'd3,  cls: 3'd1, vc: 1'b0, len: 5'd4,  base: 32'hA0,    exp_hdr: 32'h1928_0000, exp_flits: 5};
    vecs[2] = '{dest: 5'd31, cls: 3'd7, vc: 1'b1, len: 5'd2,  base: 32'h1000,  exp_hdr: 32'hFF28_0000, exp_flits: 3};
    vecs[3] = '{dest: 5'd0,  cls: 3'd0, vc: 1'b0, len: 5'd16, base: 32'h2000,  exp_hdr: 32'h0028_0000, exp_flits: 17};
    vecs[4] = '{dest: 5'd10, cls: 3'd5, vc: 1'b1, len: 5'd31, base: 32'h3000,  exp_hdr: 32'h5528_0000, exp_flits: 17};
    vecs[5] = '{dest: 5'd17, cls: 3'd2, vc: 1'b0, len: 5'd1,  base: 32'h4000,  exp_hdr: 32'h8A28_0000, exp_flits: 2};

    rst         = 1'b1;
    req_dest    = '0;
    req_class   = '0;
    req_vc      = '0;
    req_len     = '0;
    req_valid   = 1'b0;
    data_flit   = '0;
    data_valid  = 1'b0;
    fixed_ready = 2'b11;
    rand_mode   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_flit", 64'(out_flit), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pkt_sent", 64'(pkt_sent), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_data_ready", 64'(data_ready), 64'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].dest, vecs[i].cls, vecs[i].vc, vecs[i].len, vecs[i].base);
      checkOutput(vecs[i]);
    end

    // VC1 header stalled while only VC0 is ready
    fixed_ready = 2'b01;
    sendReq(5'd5, 3'd3, 1'b1, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'(2'b10));
      chk("stall_flit", 64'(out_flit), 64'(32'h2B28_0000));
      @(posedge clk);
      #1;
    end
    fixed_ready = 2'b10;
    @(negedge clk);
    chk("stall_release_pkt_sent", 64'(pkt_sent), 64'(1));
    @(posedge clk);
    #1;
    fixed_ready = 2'b11;
    waitIdle();
    chk("stall_hdr", 64'(last_hdr), 64'(32'h2B28_0000));

    // Back-to-back len 2 and len 1: five transfers on consecutive cycles
    xfer_cyc.delete();
    applyStimulus(5'd7, 3'd4, 1'b0, 5'd2, 32'h5000);
    applyStimulus(5'd8, 3'd6, 1'b1, 5'd1, 32'h6000);
    waitIdle();
    chk("b2b_count", 64'(xfer_cyc.size()), 64'(5));
    if (xfer_cyc.size() >= 5) chk("b2b_span", 64'(xfer_cyc[4] - xfer_cyc[0]), 64'(4));

    // Reset while the second payload flit sits in the output register
    sendReq(5'd3, 3'd1, 1'b0, 5'd4);
    sendData(32'hB0);
    sendData(32'hB1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(DW'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                    VW'($urandom_range(0, 1)), LW'($urandom_range(0, 20)), FW'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_mode = 1'b0;
    waitIdle();
    chk("queue_empty", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
